// File: rtl/neuron_timestep_scheduler.sv
// neuron_timestep_scheduler: event FIFO plus drain/settle/clear sequencer for one neuron-group timestep
module neuron_timestep_scheduler #(
  parameter int ADDR_W = 12,
  parameter int FIFO_DEPTH = 16,
  parameter int N_NEURONS = 8,
  parameter int SETTLE_CYCLES = 4,
  parameter logic [ADDR_W-1:0] SRC_IDLE = 12'hFFF
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic [ADDR_W-1:0]             in_src_addr,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          ts_start,
  output logic [ADDR_W-1:0]             src_addr_out,
  output logic                          src_valid_out,
  output logic                          clear_out,
  input  logic [N_NEURONS-1:0]          neuron_spikes,
  output logic [N_NEURONS-1:0]          spike_vec,
  output logic                          spike_vec_valid,
  output logic                          ts_busy,
  output logic [15:0]                   ts_count,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, DRAIN, SETTLE, CLEAR} state_e;
  state_e state_q, state_d;
  logic [ADDR_W-1:0] mem_q [FIFO_DEPTH];
  logic [LW-1:0] wr_q, wr_d, rd_q, rd_d, rem_q, rem_d;
  logic [SW-1:0] scnt_q, scnt_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic src_v_q, src_v_d;
  logic [N_NEURONS-1:0] spk_q, spk_d;
  logic [15:0] ts_cnt_q, ts_cnt_d;
  logic push, pop, empty, full;
  assign fifo_level = wr_q - rd_q;
  assign empty = fifo_level == '0;
  assign full = fifo_level == LW'(FIFO_DEPTH);
  // The first event leaves on the ts_start edge so it is on the bus in the very next cycle;
  // rem_q counts the snapshot entries still to pop after the one currently shown.
  assign pop = (state_q == IDLE && ts_start && !empty) || (state_q == DRAIN && rem_q != '0);
  // A full FIFO still takes an entry in a cycle that frees one.
  assign in_ready = !full || pop;
  assign push = in_valid && in_ready;
  assign src_addr_out = src_q;
  assign src_valid_out = src_v_q;
  assign clear_out = state_q == CLEAR;
  assign spike_vec_valid = state_q == CLEAR;
  assign spike_vec = spk_q;
  assign ts_busy = state_q != IDLE;
  assign ts_count = ts_cnt_q;
  // FIFO storage; contents need no reset because the pointers gate every read
  always_ff @(posedge CLK)
    if (push) mem_q[wr_q[AW-1:0]] <= in_src_addr;
  // Next-state, pointer, bus and counter logic
  always_comb begin
    state_d = state_q;
    rem_d = rem_q;
    scnt_d = scnt_q;
    spk_d = spk_q;
    ts_cnt_d = ts_cnt_q;
    wr_d = wr_q + LW'(push);
    rd_d = rd_q + LW'(pop);
    src_d = pop ? mem_q[rd_q[AW-1:0]] : SRC_IDLE;
    src_v_d = pop;
    case (state_q)
      IDLE: if (ts_start) begin
        state_d = DRAIN;
        rem_d = empty ? '0 : fifo_level - 1'b1;
      end
      DRAIN: if (rem_q == '0) begin
        state_d = SETTLE;
        scnt_d = '0;
      end else rem_d = rem_q - 1'b1;
      SETTLE: if (scnt_q == SW'(SETTLE_CYCLES - 1)) begin
        state_d = CLEAR;
        spk_d = neuron_spikes;
      end else scnt_d = scnt_q + 1'b1;
      CLEAR: begin
        state_d = IDLE;
        ts_cnt_d = ts_cnt_q + 16'd1;
      end
      default: state_d = IDLE;
    endcase
  end
  // State register; reset aborts any timestep in progress without a clear pulse
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      wr_q <= '0;
      rd_q <= '0;
      rem_q <= '0;
      scnt_q <= '0;
      src_q <= SRC_IDLE;
      src_v_q <= 1'b0;
      spk_q <= '0;
      ts_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      rem_q <= rem_d;
      scnt_q <= scnt_d;
      src_q <= src_d;
      src_v_q <= src_v_d;
      spk_q <= spk_d;
      ts_cnt_q <= ts_cnt_d;
    end
  end
endmodule

// File: tb/tb_neuron_timestep_scheduler.sv
// tb_neuron_timestep_scheduler: table-driven timesteps plus corner sequences with an event scoreboard
module tb_neuron_timestep_scheduler;
  logic CLK, RESET, in_valid, in_ready, ts_start;
  logic [11:0] in_src_addr, src_addr_out;
  logic src_valid_out, clear_out, spike_vec_valid, ts_busy;
  logic [7:0] neuron_spikes, spike_vec;
  logic [15:0] ts_count;
  logic [4:0] fifo_level;
  int checks = 0, errors = 0, cyc = 0;
  int start_cyc = 0, ev_idx = 0, exp_clr = -100, exp_off = 0, nclr = 0;
  logic [7:0] spk_pat = 8'h00;
  logic mon_en = 1'b0;
  logic [11:0] sbq[$];
  typedef struct {
    int n;
    logic [7:0] spk;
    int off;
    logic [7:0] exp_vec;
  } vec_t;
  vec_t vt[5];

  neuron_timestep_scheduler dut (
    .CLK(CLK), .RESET(RESET), .in_src_addr(in_src_addr), .in_valid(in_valid),
    .in_ready(in_ready), .ts_start(ts_start), .src_addr_out(src_addr_out),
    .src_valid_out(src_valid_out), .clear_out(clear_out), .neuron_spikes(neuron_spikes),
    .spike_vec(spike_vec), .spike_vec_valid(spike_vec_valid), .ts_busy(ts_busy),
    .ts_count(ts_count), .fifo_level(fifo_level)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic push(input logic [11:0] a);
    in_valid = 1'b1;
    in_src_addr = a;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic start;
    ts_start = 1'b1;
    tick();
    ts_start = 1'b0;
  endtask

  task automatic wait_idle;
    for (int k = 0; k < 100 && ts_busy; k++) tick();
    chk("idle_timeout", ts_busy, 0);
  endtask

  // Spike pattern appears only in the cycle before the expected clear
  initial begin
    neuron_spikes = 8'h00;
    forever begin
      @(posedge CLK);
      #1;
      neuron_spikes = (cyc == exp_clr - 1) ? spk_pat : 8'h00;
    end
  end

  // Monitor: scoreboard on the bus, clear timing, and capture of accepted pushes
  always @(negedge CLK) if (mon_en) begin
    if (src_valid_out) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event actual=%0h expected=none", src_addr_out);
      end else chk("src_addr", src_addr_out, sbq.pop_front());
      chk("event_cycle", cyc, start_cyc + 1 + ev_idx);
      ev_idx++;
    end else chk("idle_addr", src_addr_out, 12'hFFF);
    if (clear_out) begin
      nclr++;
      chk("clear_cycle", cyc, exp_clr);
      chk("svv_with_clear", spike_vec_valid, 1);
      chk("spike_vec_at_clear", spike_vec, spk_pat);
    end else chk("svv_alone", spike_vec_valid, 0);
    if (ts_start && !ts_busy && !RESET) begin
      start_cyc = cyc;
      ev_idx = 0;
      exp_clr = cyc + exp_off;
    end
    if (RESET) sbq.delete();
    else if (in_valid && in_ready) sbq.push_back(in_src_addr);
  end

  initial begin
    int c0, n0;
    vt[0] = '{3, 8'hA5, 8, 8'hA5};
    vt[1] = '{0, 8'h3C, 6, 8'h3C};
    vt[2] = '{1, 8'hFF, 6, 8'hFF};
    vt[3] = '{5, 8'h01, 10, 8'h01};
    vt[4] = '{2, 8'h00, 7, 8'h00};
    RESET = 1'b1;
    in_valid = 1'b0;
    in_src_addr = 12'h000;
    ts_start = 1'b0;
    tick();
    tick();
    RESET = 1'b0;
    mon_en = 1'b1;
    chk("rst_src_addr", src_addr_out, 12'hFFF);
    chk("rst_src_valid", src_valid_out, 0);
    chk("rst_clear", clear_out, 0);
    chk("rst_svv", spike_vec_valid, 0);
    chk("rst_busy", ts_busy, 0);
    chk("rst_ts_count", ts_count, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_spike_vec", spike_vec, 0);
    chk("rst_in_ready", in_ready, 1);
    for (int i = 0; i < 5; i++) begin
      c0 = ts_count;
      n0 = nclr;
      for (int j = 0; j < vt[i].n; j++) push(12'(i * 16 + j + 1));
      chk("tbl_level_pre", fifo_level, vt[i].n);
      exp_off = vt[i].off;
      spk_pat = vt[i].spk;
      start();
      chk("tbl_busy", ts_busy, 1);
      wait_idle();
      chk("tbl_ts_count", ts_count, c0 + 1);
      chk("tbl_level_post", fifo_level, 0);
      chk("tbl_nclr", nclr, n0 + 1);
      chk("tbl_events", ev_idx, vt[i].n);
      chk("tbl_spike_vec", spike_vec, vt[i].exp_vec);
      chk("tbl_sb_empty", sbq.size(), 0);
    end
    for (int j = 0; j < 16; j++) push(12'h300 + 12'(j));
    chk("full_level", fifo_level, 16);
    chk("full_not_ready", in_ready, 0);
    in_valid = 1'b1;
    in_src_addr = 12'hABC;
    tick();
    tick();
    chk("held_level", fifo_level, 16);
    exp_off = 21;
    spk_pat = 8'h81;
    c0 = ts_count;
    start();
    in_valid = 1'b0;
    chk("push_pop_full_level", fifo_level, 16);
    wait_idle();
    chk("k16_events", ev_idx, 16);
    chk("late_level", fifo_level, 1);
    chk("late_sb", sbq.size(), 1);
    chk("k16_ts_count", ts_count, c0 + 1);
    exp_off = 6;
    spk_pat = 8'h5A;
    start();
    wait_idle();
    chk("late_events", ev_idx, 1);
    chk("late_drained", fifo_level, 0);
    chk("late_spike_vec", spike_vec, 8'h5A);
    for (int j = 0; j < 5; j++) push(12'h200 + 12'(j));
    c0 = ts_count;
    n0 = nclr;
    exp_off = 10;
    spk_pat = 8'hEE;
    start();
    tick();
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    chk("abort_busy", ts_busy, 0);
    chk("abort_level", fifo_level, 0);
    chk("abort_src_valid", src_valid_out, 0);
    chk("abort_events", ev_idx, 2);
    chk("abort_ts_count", ts_count, 0);
    chk("abort_spike_vec", spike_vec, 0);
    repeat (14) tick();
    chk("abort_no_clear", nclr, n0);
    chk("abort_still_idle", ts_busy, 0);
    force dut.ts_cnt_q = 16'hFFFF;
    tick();
    release dut.ts_cnt_q;
    tick();
    chk("preload", ts_count, 16'hFFFF);
    n0 = nclr;
    exp_off = 6;
    spk_pat = 8'h42;
    start();
    tick();
    ts_start = 1'b1;
    tick();
    ts_start = 1'b0;
    wait_idle();
    chk("wrap_ts_count", ts_count, 0);
    chk("wrap_nclr", nclr, n0 + 1);
    repeat (10) tick();
    chk("ignored_start_busy", ts_busy, 0);
    chk("ignored_start_nclr", nclr, n0 + 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
